// File: rtl/div_sched_if.sv
//------------------------------------------------------------------------------
// Module  : div_sched_if
// Brief   : EX-stage request/result bundle between the pipeline and div_sched.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface div_sched_if #(
    parameter int WIDTH = 32
);
    logic             div_en;
    logic [3:0]       div_op;
    logic [WIDTH-1:0] div_src1;
    logic [WIDTH-1:0] div_src2;
    logic             flush;
    logic             out_ready;
    logic             div_idle;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_result;

    modport master (
        output div_en, div_op, div_src1, div_src2, flush, out_ready,
        input  div_idle, div_busy, div_done, div_result
    );

    modport slave (
        input  div_en, div_op, div_src1, div_src2, flush, out_ready,
        output div_idle, div_busy, div_done, div_result
    );
endinterface

`default_nettype wire

// File: rtl/div_sched.sv
//------------------------------------------------------------------------------
// Module  : div_sched
// Brief   : Multi-cycle radix-2 restoring divide scheduler for the EX stage.
//           Optional macro DIV_SCHED_EARLY_OUT_EN skips iteration for trivial
//           operands (zero divisor or |dividend| < |divisor|).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_sched #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  wire logic   clk,
    input  wire logic   reset,
    div_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend shifts out of the top, quotient in at the bottom
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               sel_rem_q, sel_rem_d;

    logic               w_signed;
    logic               w_sel_rem;
    logic [WIDTH-1:0]   w_mag1, w_mag2;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt;

    function automatic logic [WIDTH-1:0] fixup(
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] rem,
        input logic             qn,
        input logic             rn,
        input logic             sel
    );
        if (sel)
            return rn ? -rem : rem;
        else
            return qn ? -quo : quo;
    endfunction

    // Lowest set bit of div_op wins; an all-zero op behaves as div.wu.
    always_comb begin
        w_signed  = 1'b0;
        w_sel_rem = 1'b0;
        if (bus.div_op[0]) begin
            w_signed = 1'b1;
        end else if (bus.div_op[1]) begin
            w_signed = 1'b0;
        end else if (bus.div_op[2]) begin
            w_signed  = 1'b1;
            w_sel_rem = 1'b1;
        end else if (bus.div_op[3]) begin
            w_sel_rem = 1'b1;
        end
    end

    assign w_mag1 = (w_signed && bus.div_src1[WIDTH-1]) ? -bus.div_src1 : bus.div_src1;
    assign w_mag2 = (w_signed && bus.div_src2[WIDTH-1]) ? -bus.div_src2 : bus.div_src2;

    // The shifted partial remainder needs one extra bit before the compare.
    assign w_rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, dvs_q});
    assign w_diff    = w_rem_sh[WIDTH-1:0] - dvs_q;
    assign w_rem_nxt = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt = {dvd_q[WIDTH-2:0], w_ge};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        sel_rem_d = sel_rem_q;

        case (state_q)
            S_IDLE: begin
                if (bus.div_en && !bus.flush) begin
                    dvd_d     = w_mag1;
                    rem_d     = '0;
                    dvs_d     = w_mag2;
                    cnt_d     = '0;
                    q_neg_d   = w_signed & (bus.div_src1[WIDTH-1] ^ bus.div_src2[WIDTH-1]);
                    r_neg_d   = w_signed & bus.div_src1[WIDTH-1];
                    sel_rem_d = w_sel_rem;
                    state_d   = S_BUSY;
`ifdef DIV_SCHED_EARLY_OUT_EN
                    if ((w_mag2 == '0) || (w_mag1 < w_mag2)) begin
                        state_d = S_DONE;
                        res_d   = fixup((w_mag2 == '0) ? '1 : '0, w_mag1,
                                        q_neg_d, r_neg_d, sel_rem_d);
                    end
`endif
                end
            end
            S_BUSY: begin
                dvd_d = w_quo_nxt;
                rem_d = w_rem_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    res_d   = fixup(w_quo_nxt, w_rem_nxt, q_neg_q, r_neg_q, sel_rem_q);
                end
            end
            S_DONE: begin
                if (bus.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.flush)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            sel_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            sel_rem_q <= sel_rem_d;
        end
    end

    assign bus.div_idle   = (state_q == S_IDLE);
    assign bus.div_busy   = (state_q != S_IDLE);
    assign bus.div_done   = (state_q == S_DONE);
    assign bus.div_result = res_q;

endmodule

`default_nettype wire

// File: tb/tb_div_sched.sv
//------------------------------------------------------------------------------
// Module  : tb_div_sched
// Brief   : Directed self-checking bench for div_sched.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_sched;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    div_sched_if #(.WIDTH(32)) bus ();

    div_sched #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v, input bit s);
        return (s && v[31]) ? -v : v;
    endfunction

    // Cycles from the accept edge until div_done is seen.
    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit s;
        s = op[0] | (~op[1] & op[2]);
`ifdef DIV_SCHED_EARLY_OUT_EN
        if (b == 32'd0 || mag(a, s) < mag(b, s))
            return 0;
`endif
        if (s) return 32;
        return 32;
    endfunction

    task automatic wait_done(input string tag, input int lat);
        int n;
        n = 0;
        while (!bus.div_done && n < 40) begin
            step();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        bus.div_en    = 1'b1;
        bus.div_op    = op;
        bus.div_src1  = a;
        bus.div_src2  = b;
        bus.out_ready = 1'b1;
        step();
        chk({tag, " busy"}, {31'd0, bus.div_busy}, 32'd1);
        wait_done(tag, exp_lat(op, a, b));
        chk(tag, bus.div_result, exp);
        bus.div_en = 1'b0;
        step();
        chk({tag, " idle"}, {31'd0, bus.div_idle}, 32'd1);
    endtask

    initial begin
        bit seen;
        reset         = 1'b1;
        bus.div_en    = 1'b0;
        bus.div_op    = 4'b0000;
        bus.div_src1  = 32'd0;
        bus.div_src2  = 32'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst idle",   {31'd0, bus.div_idle}, 32'd1);
        chk("rst busy",   {31'd0, bus.div_busy}, 32'd0);
        chk("rst done",   {31'd0, bus.div_done}, 32'd0);
        chk("rst result", bus.div_result, 32'd0);
        reset = 1'b0;
        step();

        run_op(4'b0001, 32'd7,        32'd2,        32'h0000_0003, "div.w 7/2");
        run_op(4'b0001, 32'hFFFFFFF9, 32'd2,        32'hFFFF_FFFD, "div.w -7/2");
        run_op(4'b0100, 32'hFFFFFFF9, 32'd2,        32'hFFFF_FFFF, "mod.w -7/2");
        run_op(4'b0100, 32'd7,        32'hFFFFFFFE, 32'h0000_0001, "mod.w 7/-2");
        run_op(4'b0010, 32'hFFFFFFFF, 32'h10,       32'h0FFF_FFFF, "div.wu");
        run_op(4'b1000, 32'hFFFFFFFF, 32'h10,       32'h0000_000F, "mod.wu");
        run_op(4'b0001, 32'h80000000, 32'hFFFFFFFF, 32'h8000_0000, "div.w ovf");
        run_op(4'b0100, 32'h80000000, 32'hFFFFFFFF, 32'h0000_0000, "mod.w ovf");
        run_op(4'b0010, 32'h1234,     32'd0,        32'hFFFF_FFFF, "div.wu /0");
        run_op(4'b1000, 32'h1234,     32'd0,        32'h0000_1234, "mod.wu /0");
        run_op(4'b0001, 32'hFFFFFFF0, 32'd0,        32'h0000_0001, "div.w -16/0");
        run_op(4'b0000, 32'hFFFFFFFE, 32'd2,        32'h7FFF_FFFF, "op0 as div.wu");
        run_op(4'b0101, 32'hFFFFFFF9, 32'd2,        32'hFFFF_FFFD, "op prio");
        run_op(4'b0001, 32'd3,        32'd5,        32'h0000_0000, "div.w 3/5");

        // Flush ten cycles into an operation
        bus.div_en   = 1'b1;
        bus.div_op   = 4'b0001;
        bus.div_src1 = 32'd100;
        bus.div_src2 = 32'd7;
        step();
        bus.div_en = 1'b0;
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        chk("flush idle", {31'd0, bus.div_idle}, 32'd1);
        chk("flush done", {31'd0, bus.div_done}, 32'd0);
        bus.flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            step();
            if (bus.div_done) seen = 1'b1;
        end
        chk("flush no result", {31'd0, seen}, 32'd0);
        run_op(4'b0001, 32'd100, 32'd7, 32'h0000_000E, "div.w 100/7");

        // Flush and request in the same idle cycle
        bus.div_en = 1'b1;
        bus.flush  = 1'b1;
        step();
        chk("flush+en idle", {31'd0, bus.div_idle}, 32'd1);
        chk("flush+en busy", {31'd0, bus.div_busy}, 32'd0);
        bus.div_en = 1'b0;
        bus.flush  = 1'b0;
        step();

        // Back-pressure; operands change after accept and must not be re-sampled
        bus.out_ready = 1'b0;
        bus.div_en    = 1'b1;
        bus.div_op    = 4'b0010;
        bus.div_src1  = 32'hFFFFFFFF;
        bus.div_src2  = 32'h10;
        step();
        chk("bp busy", {31'd0, bus.div_busy}, 32'd1);
        bus.div_op   = 4'b0100;
        bus.div_src1 = 32'd7;
        bus.div_src2 = 32'hFFFFFFFE;
        wait_done("bp", exp_lat(4'b0010, 32'hFFFFFFFF, 32'h10));
        chk("bp result", bus.div_result, 32'h0FFF_FFFF);
        repeat (5) begin
            step();
            chk("bp done held",   {31'd0, bus.div_done}, 32'd1);
            chk("bp result held", bus.div_result, 32'h0FFF_FFFF);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp handshake idle", {31'd0, bus.div_idle}, 32'd1);
        step();
        chk("bp next accept", {31'd0, bus.div_busy}, 32'd1);
        wait_done("bp next", exp_lat(4'b0100, 32'd7, 32'hFFFFFFFE));
        chk("bp next result", bus.div_result, 32'h0000_0001);
        bus.div_en = 1'b0;
        step();

        // Reset in the middle of an operation
        bus.div_en   = 1'b1;
        bus.div_op   = 4'b0001;
        bus.div_src1 = 32'd7;
        bus.div_src2 = 32'd2;
        step();
        bus.div_en = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        chk("mid rst idle",   {31'd0, bus.div_idle}, 32'd1);
        chk("mid rst done",   {31'd0, bus.div_done}, 32'd0);
        chk("mid rst result", bus.div_result, 32'd0);
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
